// File: rtl/ee354_matrix_pkg.sv
// Shared definitions for the matrix loader: default sizes, one-hot FSM
// states, flat-bus indexing and the power-up identity image.
package ee354_matrix_pkg;

    localparam int N_DEF     = 8;
    localparam int W_DEF     = 8;
    // Widest matrix image the identity helper can build (N*N*W bits).
    localparam int MAT_W_MAX = 4096;

    typedef enum logic [3:0] {
        LOAD  = 4'b0001,
        START = 4'b0010,
        WAIT  = 4'b0100,
        HOLD  = 4'b1000
    } state_t;

    // Bit offset of entry (r,c) inside the row-major flat matrix bus.
    function automatic int flat_idx(input int r, input int c,
                                    input int n = N_DEF, input int w = W_DEF);
        return (r * n + c) * w;
    endfunction

    // Identity matrix image; callers keep the low N*N*W bits.
    function automatic logic [MAT_W_MAX-1:0] identity_matrix(input int n = N_DEF,
                                                             input int w = W_DEF);
        logic [MAT_W_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) begin
            m[flat_idx(i, i, n, w)] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ee354_rowcol_counter.sv
// Row-major (Row,Col) wrap counter over an N x N grid. Clear beats
// increment; the last cell wraps back to (0,0). Also used by the result
// display scanner.
module ee354_rowcol_counter #(
    parameter int N  = 8,
    parameter int RW = $clog2(N)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          inc,
    input  logic          clr,
    output logic [RW-1:0] Row,
    output logic [RW-1:0] Col,
    output logic          last
);

    localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

    assign last = (Row == LAST_IDX) && (Col == LAST_IDX);

    // Advance column first, carry into the row, wrap both at the last cell.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Row <= '0;
            Col <= '0;
        end else if (clr) begin
            Row <= '0;
            Col <= '0;
        end else if (inc) begin
            if (Col == LAST_IDX) begin
                Col <= '0;
                Row <= (Row == LAST_IDX) ? '0 : Row + 1'b1;
            end else begin
                Col <= Col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ee354_matrix_loader.sv
// Matrix input stage: fills an N x N matrix from the switches one entry per
// button pulse, then runs the Start/Ack handshake with the processing core.
// The matrix only changes while the FSM sits in LOAD.
module ee354_matrix_loader
    import ee354_matrix_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [W-1:0]               Sw,
    input  logic                       Load_Pulse,
    input  logic                       Skip_Pulse,
    input  logic                       Clear_Pulse,
    input  logic                       Start_Pulse,
    input  logic                       Ack_Pulse,
    input  logic                       Core_Done,
    output logic [N*N*W-1:0]           Mat_Flat,
    output logic [$clog2(N)-1:0]       Row,
    output logic [$clog2(N)-1:0]       Col,
    output logic [W-1:0]               Cur_Entry,
    output logic [$clog2(N*N+1)-1:0]   Written,
    output logic                       Full,
    output logic                       Core_Start,
    output logic                       Core_Ack,
    output logic                       q_Load,
    output logic                       q_Start,
    output logic                       q_Wait,
    output logic                       q_Hold
);

    localparam int MAT_W = N * N * W;
    localparam int RW    = $clog2(N);
    localparam int CW    = $clog2(N * N + 1);

    localparam logic [MAT_W_MAX-1:0] IDENT_FULL = identity_matrix(N, W);
    localparam logic [MAT_W-1:0]     IDENT      = IDENT_FULL[MAT_W-1:0];
    localparam logic [CW-1:0]        FULL_CNT   = CW'(N * N);

    state_t         state;
    logic [MAT_W-1:0] mat_flat;
    logic           in_load;
    logic           do_clear;
    logic           do_load;
    logic           do_skip;
    logic           do_start;
    logic           pos_last;
    int             wr_idx;

    // Pulses only act in LOAD; Clear > Load > Skip > Start, losers dropped.
    assign in_load  = (state == LOAD);
    assign do_clear = in_load & Clear_Pulse;
    assign do_load  = in_load & ~Clear_Pulse & Load_Pulse;
    assign do_skip  = in_load & ~Clear_Pulse & ~Load_Pulse & Skip_Pulse;
    assign do_start = in_load & ~Clear_Pulse & ~Load_Pulse & ~Skip_Pulse & Start_Pulse;

    ee354_rowcol_counter #(
        .N  (N),
        .RW (RW)
    ) u_pos (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (do_load | do_skip),
        .clr   (do_clear),
        .Row   (Row),
        .Col   (Col),
        .last  (pos_last)
    );

    // Bit offset of the entry currently addressed by (Row,Col).
    always_comb begin
        wr_idx = flat_idx(int'(Row), int'(Col), N, W);
    end

    // Matrix storage and write count; identity is the reset/clear image.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mat_flat <= IDENT;
            Written  <= '0;
        end else if (do_clear) begin
            mat_flat <= IDENT;
            Written  <= '0;
        end else if (do_load) begin
            mat_flat[wr_idx +: W] <= Sw;
            if (Written != FULL_CNT) begin
                Written <= Written + 1'b1;
            end
        end
    end

    // Handshake FSM; Core_Start/Core_Ack are one-cycle registered pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= LOAD;
            Core_Start <= 1'b0;
            Core_Ack   <= 1'b0;
        end else begin
            Core_Start <= 1'b0;
            Core_Ack   <= 1'b0;
            case (state)
                LOAD: begin
                    if (do_start) begin
                        state      <= START;
                        Core_Start <= 1'b1;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (Core_Done) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (Ack_Pulse) begin
                        state    <= LOAD;
                        Core_Ack <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign Mat_Flat  = mat_flat;
    assign Cur_Entry = mat_flat[wr_idx +: W];
    assign Full      = (Written == FULL_CNT);
    assign q_Load    = (state == LOAD);
    assign q_Start   = (state == START);
    assign q_Wait    = (state == WAIT);
    assign q_Hold    = (state == HOLD);

endmodule

// File: tb/tb_ee354_matrix_loader.sv
// Self-checking bench for ee354_matrix_loader (N=8, W=8).
module tb_ee354_matrix_loader;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [7:0]   Sw;
    logic         Load_Pulse, Skip_Pulse, Clear_Pulse, Start_Pulse, Ack_Pulse;
    logic         Core_Done;
    logic [511:0] Mat_Flat;
    logic [2:0]   Row, Col;
    logic [7:0]   Cur_Entry;
    logic [6:0]   Written;
    logic         Full, Core_Start, Core_Ack;
    logic         q_Load, q_Start, q_Wait, q_Hold;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] sw;
        logic       ld, sk, cl;
        int         er, ec, ew;
        logic [7:0] ecur;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } sb_t;

    vec_t         vecs[13];
    sb_t          sbq[$];
    logic [511:0] ident;
    logic [511:0] exp_mat;

    ee354_matrix_loader #(.N(8), .W(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Sw          (Sw),
        .Load_Pulse  (Load_Pulse),
        .Skip_Pulse  (Skip_Pulse),
        .Clear_Pulse (Clear_Pulse),
        .Start_Pulse (Start_Pulse),
        .Ack_Pulse   (Ack_Pulse),
        .Core_Done   (Core_Done),
        .Mat_Flat    (Mat_Flat),
        .Row         (Row),
        .Col         (Col),
        .Cur_Entry   (Cur_Entry),
        .Written     (Written),
        .Full        (Full),
        .Core_Start  (Core_Start),
        .Core_Ack    (Core_Ack),
        .q_Load      (q_Load),
        .q_Start     (q_Start),
        .q_Wait      (q_Wait),
        .q_Hold      (q_Hold)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] entry(input int r, input int c);
        return Mat_Flat[(r * 8 + c) * 8 +: 8];
    endfunction

    // Called at a negedge: drive pulses for exactly one posedge, return at the next negedge.
    task automatic step(input logic [7:0] sw, input logic ld, input logic sk,
                        input logic cl, input logic st, input logic ak);
        Sw = sw; Load_Pulse = ld; Skip_Pulse = sk; Clear_Pulse = cl;
        Start_Pulse = st; Ack_Pulse = ak;
        @(negedge Clk);
        Load_Pulse = 0; Skip_Pulse = 0; Clear_Pulse = 0; Start_Pulse = 0; Ack_Pulse = 0;
    endtask

    task automatic sb_push(input int r, input int c, input logic [7:0] v);
        sb_t e;
        e.idx = (r * 8 + c) * 8;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic sb_drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("sb_entry", Mat_Flat[e.idx +: 8], e.val);
        end
    endtask

    initial begin
        ident = '0;
        for (int i = 0; i < 8; i++) ident[(i * 8 + i) * 8] = 1'b1;

        //            sw     ld sk cl  row col wr cur
        vecs[0]  = '{8'h3C, 1, 0, 0,  0, 1, 1, 8'h00};
        vecs[1]  = '{8'h11, 0, 1, 0,  0, 2, 1, 8'h00};
        vecs[2]  = '{8'h22, 1, 0, 0,  0, 3, 2, 8'h00};
        vecs[3]  = '{8'h00, 0, 1, 0,  0, 4, 2, 8'h00};
        vecs[4]  = '{8'h00, 0, 1, 0,  0, 5, 2, 8'h00};
        vecs[5]  = '{8'h00, 0, 1, 0,  0, 6, 2, 8'h00};
        vecs[6]  = '{8'h00, 0, 1, 0,  0, 7, 2, 8'h00};
        vecs[7]  = '{8'h00, 0, 1, 0,  1, 0, 2, 8'h00};
        vecs[8]  = '{8'h00, 0, 1, 0,  1, 1, 2, 8'h01};
        vecs[9]  = '{8'h77, 1, 0, 0,  1, 2, 3, 8'h00};
        vecs[10] = '{8'h00, 0, 0, 1,  0, 0, 0, 8'h01};
        vecs[11] = '{8'h5A, 1, 1, 0,  0, 1, 1, 8'h00};
        vecs[12] = '{8'h99, 1, 0, 1,  0, 0, 0, 8'h01};

        Reset = 1; Sw = 0; Core_Done = 0;
        Load_Pulse = 0; Skip_Pulse = 0; Clear_Pulse = 0; Start_Pulse = 0; Ack_Pulse = 0;
        repeat (3) @(negedge Clk);
        Reset = 0;

        // Reset image
        check("rst_e00", Mat_Flat[7:0], 8'h01);
        check("rst_e01", Mat_Flat[15:8], 8'h00);
        check("rst_e77", entry(7, 7), 8'h01);
        check("rst_mat", Mat_Flat, ident);
        check("rst_qload", {q_Load, q_Start, q_Wait, q_Hold}, 4'b1000);
        check("rst_row", Row, 0);
        check("rst_col", Col, 0);
        check("rst_written", Written, 0);
        check("rst_full", Full, 0);
        check("rst_start_ack", {Core_Start, Core_Ack}, 2'b00);

        // Table-driven LOAD-state vectors
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].ld && !vecs[i].cl) sb_push(int'(Row), int'(Col), vecs[i].sw);
            step(vecs[i].sw, vecs[i].ld, vecs[i].sk, vecs[i].cl, 1'b0, 1'b0);
            sb_drain();
            check($sformatf("vec%0d_row", i), Row, vecs[i].er);
            check($sformatf("vec%0d_col", i), Col, vecs[i].ec);
            check($sformatf("vec%0d_written", i), Written, vecs[i].ew);
            check($sformatf("vec%0d_cur", i), Cur_Entry, vecs[i].ecur);
        end
        check("clrload_e00", entry(0, 0), 8'h01);

        // Fill all 64 entries, then saturate
        step(8'h00, 0, 0, 1, 0, 0);
        for (int i = 0; i < 64; i++) begin
            sb_push(i / 8, i % 8, 8'hA5);
            step(8'hA5, 1, 0, 0, 0, 0);
            sb_drain();
            if (i == 62) check("full_at63", Full, 0);
        end
        check("fill_mat", Mat_Flat, {64{8'hA5}});
        check("fill_row", Row, 0);
        check("fill_col", Col, 0);
        check("fill_written", Written, 64);
        check("fill_full", Full, 1);
        sb_push(0, 0, 8'h5E);
        step(8'h5E, 1, 0, 0, 0, 0);
        sb_drain();
        check("sat_written", Written, 64);
        check("sat_col", Col, 1);

        // Load beats Start; then a lone Start
        sb_push(0, 1, 8'h42);
        step(8'h42, 1, 0, 0, 1, 0);
        sb_drain();
        check("ldst_qload", q_Load, 1);
        check("ldst_cstart", Core_Start, 0);
        check("ldst_col", Col, 2);
        step(8'h00, 0, 0, 0, 0, 0);
        check("ldst_cstart2", Core_Start, 0);
        step(8'h00, 0, 0, 0, 1, 0);
        check("st_cstart", Core_Start, 1);
        check("st_qstart", q_Start, 1);
        step(8'h00, 0, 0, 0, 0, 0);
        check("st_cstart_drop", Core_Start, 0);
        check("st_qwait", q_Wait, 1);

        // Frozen in WAIT/HOLD, then Ack
        exp_mat = {64{8'hA5}};
        exp_mat[7:0] = 8'h5E;
        exp_mat[15:8] = 8'h42;
        step(8'hFF, 1, 1, 1, 1, 1);
        check("wait_mat", Mat_Flat, exp_mat);
        check("wait_state", {q_Load, q_Start, q_Wait, q_Hold}, 4'b0010);
        check("wait_col", Col, 2);
        check("wait_ack", Core_Ack, 0);
        Core_Done = 1;
        step(8'h00, 0, 0, 0, 0, 0);
        check("hold_state", {q_Load, q_Start, q_Wait, q_Hold}, 4'b0001);
        step(8'hFF, 1, 0, 0, 1, 0);
        check("hold_mat", Mat_Flat, exp_mat);
        check("hold_state2", q_Hold, 1);
        check("hold_cstart", Core_Start, 0);
        step(8'h00, 0, 0, 0, 0, 1);
        check("ack_cack", Core_Ack, 1);
        check("ack_qload", q_Load, 1);
        check("ack_cstart", Core_Start, 0);
        Core_Done = 0;
        step(8'h00, 0, 0, 0, 0, 0);
        check("ack_drop", Core_Ack, 0);
        check("ack_row", Row, 0);
        check("ack_col", Col, 2);
        check("ack_written", Written, 64);
        check("ack_mat", Mat_Flat, exp_mat);

        // Core_Done already high when WAIT is entered
        Core_Done = 1;
        step(8'h00, 0, 0, 0, 1, 0);
        check("pre_qstart", q_Start, 1);
        step(8'h00, 0, 0, 0, 0, 0);
        check("pre_qwait", q_Wait, 1);
        step(8'h00, 0, 0, 0, 0, 0);
        check("pre_qhold", q_Hold, 1);
        step(8'h00, 0, 0, 0, 0, 1);
        check("pre_qload", q_Load, 1);
        Core_Done = 0;
        step(8'h00, 0, 0, 0, 0, 0);

        // Asynchronous reset in WAIT
        step(8'h00, 0, 0, 0, 1, 0);
        step(8'h00, 0, 0, 0, 0, 0);
        check("arst_pre_wait", q_Wait, 1);
        #2 Reset = 1;
        #1;
        check("arst_state", {q_Load, q_Start, q_Wait, q_Hold}, 4'b1000);
        check("arst_mat", Mat_Flat, ident);
        check("arst_rowcol", {Row, Col}, 6'd0);
        check("arst_written", Written, 0);
        check("arst_full", Full, 0);
        check("arst_start_ack", {Core_Start, Core_Ack}, 2'b00);
        @(negedge Clk);
        Reset = 0;

        // Asynchronous reset while Core_Start is high
        step(8'h00, 0, 0, 0, 1, 0);
        check("arst2_cstart_pre", Core_Start, 1);
        #2 Reset = 1;
        #1;
        check("arst2_cstart", Core_Start, 0);
        check("arst2_qload", q_Load, 1);
        @(negedge Clk);
        Reset = 0;
        step(8'h00, 0, 0, 0, 0, 0);
        check("arst2_stay_load", q_Load, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ee354_matrix_loader.md
Name: ee354_matrix_loader

Overview:
Upstream input stage for the matrix-processing core. Builds an N×N matrix of W-bit entries from the board switches, one entry per debounced button pulse, in row-major order. The matrix powers up as the identity. Presents the matrix as a flat bus, and sequences the core's Start/Ack handshake so that the matrix is frozen while the core runs.

Parameters:
N, 8, matrix dimension (rows = cols = N), N ≥ 2
W, 8, entry width in bits

Ports:
Clk  in  1  system clock; all state updates on posedge
Reset  in  1  asynchronous, active-high; restores the identity matrix and state LOAD
Sw  in  W  switch value to deposit
Load_Pulse  in  1  one-cycle pulse: write Sw at (Row,Col), then advance
Skip_Pulse  in  1  one-cycle pulse: advance without writing
Clear_Pulse  in  1  one-cycle pulse: restore identity, Row=Col=0, Written=0
Start_Pulse  in  1  one-cycle pulse: hand the matrix to the core
Ack_Pulse  in  1  one-cycle pulse: user acknowledges the core result
Core_Done  in  1  level from the core, high while the core is in its done state
Mat_Flat  out  N*N*W  entry (r,c) sits at bits [((r*N+c)+1)*W-1 : (r*N+c)*W]
Row  out  clog2(N)  current write row
Col  out  clog2(N)  current write column
Cur_Entry  out  W  matrix entry at (Row,Col), combinational, for SSD display
Written  out  clog2(N*N+1)  count of Load writes since the last clear, saturating at N*N
Full  out  1  high when Written == N*N
Core_Start  out  1  one-cycle start pulse to the core
Core_Ack  out  1  one-cycle ack pulse to the core
q_Load, q_Start, q_Wait, q_Hold  out  1 each  one-hot state flags, for the LEDs

Behaviour:
- Reset values:
  - Mat_Flat = identity: entry (i,i) = 1, all other entries = 0.
  - Row = Col = 0, Written = 0, Full = 0.
  - Core_Start = Core_Ack = 0.
  - State LOAD (q_Load = 1, other state flags 0).
- Reset asserted in any state aborts the operation immediately. It does not wait for Core_Done.
- State machine (one-hot, registered):
  - LOAD:
    - Load_Pulse: the entry at (Row,Col) takes Sw. Written increments, saturating at N*N. The position advances.
    - Skip_Pulse: the position advances with no write and Written is unchanged.
    - Clear_Pulse: identity restored, Row = Col = 0, Written = 0.
    - Start_Pulse: go to START.
  - START: Core_Start = 1 for exactly this cycle. Unconditionally go to WAIT.
  - WAIT: hold until Core_Done = 1, then go to HOLD.
  - HOLD: on Ack_Pulse, Core_Ack = 1 for exactly the next cycle and go to LOAD. The matrix, Row, Col and Written are retained so the user can edit further.
- Advance rule:
  - Col increments.
  - At Col = N-1, Col wraps to 0 and Row increments.
  - At (N-1,N-1), both wrap to (0,0). Wrap-around does not clear Written.
- Priority within LOAD when pulses coincide in one cycle: Clear > Load > Skip > Start.
  - Only the highest-priority pulse acts; the others are dropped.
  - Example: Load and Start together means the write happens and the state stays in LOAD.
- In START, WAIT and HOLD, the matrix is frozen:
  - Load, Skip, Clear and Start pulses are ignored.
  - Ack_Pulse is ignored everywhere except HOLD.
- Core_Done already high on entering WAIT: transition to HOLD on the first WAIT cycle. No edge is required.
- Latency:
  - A written entry appears on Mat_Flat and Cur_Entry on the cycle after Load_Pulse.
  - Core_Start rises 1 cycle after Start_Pulse.
- Core_Start and Core_Ack are registered outputs. They are never high simultaneously.
- Cur_Entry is the combinational mux of Mat_Flat indexed by the registered Row and Col.

Decomposition:
- Package ee354_matrix_pkg holds:
  - N_DEF = 8 and W_DEF = 8.
  - One-hot state constants LOAD = 4'b0001, START = 4'b0010, WAIT = 4'b0100, HOLD = 4'b1000.
  - Function flat_idx(r,c) returning (r*N+c)*W.
  - Function identity_matrix() returning the N*N*W reset image.
- One sub-module, ee354_rowcol_counter:
  - Row-major wrap counter with inputs inc and clr; outputs Row, Col and last = (N-1,N-1).
  - Shared with the downstream result-display scanner.

Test Plan:
1. Reset, then inspect → Mat_Flat[7:0] = 1, Mat_Flat[15:8] = 0, the entry at (7,7) = 1, q_Load = 1, Row = Col = 0.
2. Sw = 8'h3C, Load_Pulse → the next cycle shows entry (0,0) = 8'h3C, Col = 1, Written = 1, Cur_Entry = 0 (identity value at (0,1)).
3. 64 Load_Pulses with Sw = 8'hA5 → all entries = 8'hA5, Row = Col = 0, Written = 64, Full = 1. A 65th Load keeps Written = 64 and overwrites (0,0).
4. Load_Pulse and Start_Pulse in the same cycle → the write occurs and Core_Start stays 0. A lone Start_Pulse then gives Core_Start = 1 for exactly 1 cycle, one cycle later, followed by q_Wait = 1.
5. In WAIT, Load_Pulse with Sw = 8'hFF → matrix unchanged. Core_Done = 1 → q_Hold. Ack_Pulse → Core_Ack high for 1 cycle, then q_Load, with Row, Col and Written preserved.
6. Reset asserted while in WAIT → outputs return to the reset values within the same cycle (asynchronous), identity restored, Core_Start = Core_Ack = 0.
